// File: rtl/ndn_link_pkg.sv
// Shared constants, state types and frame-size helper for the
// NDN router serial link endpoint.
package ndn_link_pkg;

   localparam int   TYPE_BIT         = 6;
   localparam logic START_LEVEL      = 1'b0;
   localparam logic END_LEVEL        = 1'b0;
   localparam logic IDLE_LEVEL       = 1'b1;
   localparam int   PREFIX_BYTES_DEF = 8;

   typedef enum logic [1:0] {
      R_IDLE,
      R_BYTE,
      R_END
   } rx_state_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_START,
      T_SHIFT,
      T_END
   } tx_state_t;

   // Bytes in a frame, meta byte included.
   function automatic int frame_bytes(
      input logic is_interest,
      input int   data_bytes,
      input int   prefix_bytes
   );
      if (is_interest)
         return 1 + prefix_bytes;
      return 1 + prefix_bytes + data_bytes;
   endfunction

endpackage

// File: rtl/ndn_link_tx_serializer.sv
// TX half of the link endpoint: one-byte holding register feeding a
// shift register that frames packets onto miso (start 0, bytes MSB first, end 0).
// Ports: clk, rst (async, active-high); tx_valid/tx_data/tx_ready host
// handshake; tx_busy frame in progress; tx_err underrun pulse; miso line.
module ndn_link_tx_serializer
   import ndn_link_pkg::*;
#(
   parameter int DATA_BYTES   = 32,
   parameter int PREFIX_BYTES = PREFIX_BYTES_DEF
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_err,
   output logic       miso
);

   localparam int MAX_BYTES = 1 + PREFIX_BYTES + DATA_BYTES;
   localparam int CW        = $clog2(MAX_BYTES + 1);

   localparam logic [CW-1:0] INT_LEN =
      CW'(frame_bytes(1'b1, DATA_BYTES, PREFIX_BYTES));
   localparam logic [CW-1:0] DAT_LEN =
      CW'(frame_bytes(1'b0, DATA_BYTES, PREFIX_BYTES));

   tx_state_t     st_q, st_d;
   logic [7:0]    hold_q;
   logic          hold_full;
   logic [7:0]    sh_q, sh_d;
   logic [2:0]    bit_q, bit_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [CW-1:0] len_q, len_d;
   logic          err_d;
   logic          unload;
   logic          accept;

   assign tx_ready = !hold_full;
   assign accept   = tx_valid && tx_ready;
   assign tx_busy  = (st_q != T_IDLE);

   // Holding register; full flag survives an unload if a new
   // byte lands in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q    <= '0;
         hold_full <= 1'b0;
      end else begin
         if (accept)
            hold_q <= tx_data;
         hold_full <= accept | (hold_full & ~unload);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= T_IDLE;
         sh_q   <= '0;
         bit_q  <= '0;
         idx_q  <= '0;
         len_q  <= '0;
         tx_err <= 1'b0;
      end else begin
         st_q   <= st_d;
         sh_q   <= sh_d;
         bit_q  <= bit_d;
         idx_q  <= idx_d;
         len_q  <= len_d;
         tx_err <= err_d;
      end
   end

   always_comb begin
      st_d   = st_q;
      sh_d   = sh_q;
      bit_d  = bit_q;
      idx_d  = idx_q;
      len_d  = len_q;
      err_d  = 1'b0;
      unload = 1'b0;
      miso   = IDLE_LEVEL;
      unique case (st_q)
         T_IDLE: begin
            if (hold_full)
               st_d = T_START;
         end
         T_START: begin
            miso   = START_LEVEL;
            sh_d   = hold_q;
            unload = 1'b1;
            len_d  = hold_q[TYPE_BIT] ? INT_LEN : DAT_LEN;
            idx_d  = '0;
            bit_d  = 3'd7;
            st_d   = T_SHIFT;
         end
         T_SHIFT: begin
            miso  = sh_q[7];
            sh_d  = {sh_q[6:0], 1'b0};
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) begin
               if (idx_q + CW'(1) < len_q) begin
                  if (hold_full) begin
                     sh_d   = hold_q;
                     unload = 1'b1;
                     idx_d  = idx_q + CW'(1);
                     bit_d  = 3'd7;
                  end else begin
                     // Host ran dry mid-frame: close it early.
                     st_d  = T_END;
                     err_d = 1'b1;
                  end
               end else begin
                  st_d = T_END;
               end
            end
         end
         T_END: begin
            miso = END_LEVEL;
            st_d = T_IDLE;
         end
         default: st_d = T_IDLE;
      endcase
   end

endmodule

// File: rtl/ndn_iface_link_endpoint.sv
// Interface-side end of the NDN router serial link: deserializes mosi
// frames into a byte stream and serializes host packets onto miso.
// Ports: clk, rst (async, active-high); mosi/cs from router; miso to
// router; rx_valid/rx_data/rx_sop/rx_eop/rx_err byte stream out;
// tx_valid/tx_data/tx_ready/tx_busy/tx_err host byte stream in.
module ndn_iface_link_endpoint
   import ndn_link_pkg::*;
#(
   parameter int DATA_BYTES   = 32,
   parameter int PREFIX_BYTES = PREFIX_BYTES_DEF
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       mosi,
   input  logic       cs,
   output logic       miso,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_sop,
   output logic       rx_eop,
   output logic       rx_err,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_err
);

   localparam int MAX_BYTES = 1 + PREFIX_BYTES + DATA_BYTES;
   localparam int CW        = $clog2(MAX_BYTES + 1);

   localparam logic [CW-1:0] INT_LEN =
      CW'(frame_bytes(1'b1, DATA_BYTES, PREFIX_BYTES));
   localparam logic [CW-1:0] DAT_LEN =
      CW'(frame_bytes(1'b0, DATA_BYTES, PREFIX_BYTES));

   rx_state_t     rx_st, rx_nx;
   logic [2:0]    bit_q, bit_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [CW-1:0] len_q, len_d;
   logic [CW-1:0] cur_len;
   // Only 7 bits are kept; the 8th arrives live on mosi.
   logic [6:0]    sh_q, sh_d;
   logic [7:0]    byte_in;
   logic [7:0]    data_d;
   logic          v_d, sop_d, eop_d, err_d;

   assign byte_in = {sh_q, mosi};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_st    <= R_IDLE;
         bit_q    <= '0;
         idx_q    <= '0;
         len_q    <= '0;
         sh_q     <= '0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         rx_sop   <= 1'b0;
         rx_eop   <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         rx_st    <= rx_nx;
         bit_q    <= bit_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         sh_q     <= sh_d;
         rx_valid <= v_d;
         rx_data  <= data_d;
         rx_sop   <= sop_d;
         rx_eop   <= eop_d;
         rx_err   <= err_d;
      end
   end

   always_comb begin
      rx_nx   = rx_st;
      bit_d   = bit_q;
      idx_d   = idx_q;
      len_d   = len_q;
      sh_d    = sh_q;
      data_d  = rx_data;
      v_d     = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      err_d   = 1'b0;
      cur_len = len_q;
      unique case (rx_st)
         R_IDLE: begin
            if (!cs && mosi == START_LEVEL) begin
               rx_nx = R_BYTE;
               bit_d = 3'd7;
               idx_d = '0;
            end
         end
         R_BYTE: begin
            if (cs) begin
               err_d = 1'b1;
               rx_nx = R_IDLE;
            end else begin
               sh_d  = byte_in[6:0];
               bit_d = bit_q - 3'd1;
               if (bit_q == 3'd0) begin
                  // Meta byte sets the frame length on the fly.
                  if (idx_q == '0)
                     cur_len = byte_in[TYPE_BIT] ? INT_LEN : DAT_LEN;
                  len_d  = cur_len;
                  v_d    = 1'b1;
                  data_d = byte_in;
                  sop_d  = (idx_q == '0);
                  eop_d  = (idx_q == cur_len - CW'(1));
                  idx_d  = idx_q + CW'(1);
                  bit_d  = 3'd7;
                  if (eop_d)
                     rx_nx = R_END;
               end
            end
         end
         R_END: begin
            rx_nx = R_IDLE;
            if (cs || mosi != END_LEVEL)
               err_d = 1'b1;
         end
         default: rx_nx = R_IDLE;
      endcase
   end

   ndn_link_tx_serializer #(
      .DATA_BYTES   (DATA_BYTES),
      .PREFIX_BYTES (PREFIX_BYTES)
   ) u_tx (
      .clk      (clk),
      .rst      (rst),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .tx_busy  (tx_busy),
      .tx_err   (tx_err),
      .miso     (miso)
   );

endmodule

// File: tb/tb_ndn_iface_link_endpoint.sv
// Bench for ndn_iface_link_endpoint: directed and random frames in both
// directions, compared against a frame-level model of bit positions.
`timescale 1ns/1ps
module tb_ndn_iface_link_endpoint;

   localparam int DB = 32;
   localparam int PB = 8;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst;
   logic       mosi;
   logic       cs;
   logic       miso;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_sop;
   logic       rx_eop;
   logic       rx_err;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int s0 = 0;

   logic [7:0] mon_data[$];
   logic       mon_sop[$];
   logic       mon_eop[$];
   int         mon_cyc[$];
   int         err_cyc[$];

   logic [1:0] lq[$];
   bq_t        hq;
   logic       tq_m[$];
   logic       tq_b[$];
   logic       tq_e[$];

   ndn_iface_link_endpoint #(
      .DATA_BYTES   (DB),
      .PREFIX_BYTES (PB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mosi     (mosi),
      .cs       (cs),
      .miso     (miso),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_sop   (rx_sop),
      .rx_eop   (rx_eop),
      .rx_err   (rx_err),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .tx_busy  (tx_busy),
      .tx_err   (tx_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         mon_data.push_back(rx_data);
         mon_sop.push_back(rx_sop);
         mon_eop.push_back(rx_eop);
         mon_cyc.push_back(cyc);
      end
      if (rx_err === 1'b1)
         err_cyc.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bq_t mk_rand(input bit interest);
      bq_t q;
      logic [7:0] m;
      m = 8'($urandom);
      m[6] = interest;
      q.push_back(m);
      for (int i = 0; i < PB; i++) q.push_back(8'($urandom));
      if (!interest)
         for (int i = 0; i < DB; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   function automatic bq_t mk_fixed(input bit interest);
      bq_t q;
      logic [63:0] pfx;
      pfx = 64'h0123456789ABCDEF;
      q.push_back(interest ? 8'h48 : 8'h08);
      for (int i = 7; i >= 0; i--) q.push_back(pfx[i*8 +: 8]);
      if (!interest)
         for (int i = 0; i < DB; i++) q.push_back(8'(i));
      return q;
   endfunction

   task automatic push_byte(input logic [7:0] b);
      for (int j = 7; j >= 0; j--) lq.push_back({1'b0, b[j]});
   endtask

   task automatic push_frame(input bq_t f, input logic endb);
      lq.push_back(2'b00);
      foreach (f[k]) push_byte(f[k]);
      lq.push_back({1'b0, endb});
   endtask

   // One negedge per iteration: drive mosi/cs, sample TX outputs,
   // offer the next host byte whenever the holding register is free.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) s0 = cyc + 1;
         if (lq.size() > 0) begin
            {cs, mosi} = lq.pop_front();
         end else begin
            cs   = 1'b0;
            mosi = 1'b1;
         end
         tq_m.push_back(miso);
         tq_b.push_back(tx_busy);
         tq_e.push_back(tx_err);
         if (tx_ready === 1'b1 && hq.size() > 0) begin
            tx_valid = 1'b1;
            tx_data  = hq.pop_front();
         end else begin
            tx_valid = 1'b0;
         end
      end
   endtask

   task automatic clr();
      #1;
      mon_data.delete();
      mon_sop.delete();
      mon_eop.delete();
      mon_cyc.delete();
      err_cyc.delete();
      tq_m.delete();
      tq_b.delete();
      tq_e.delete();
   endtask

   // Start bit sampled at edge s; byte k's LSB at s+8+8k, visible
   // that cycle; end bit at s+1+8*len.
   task automatic chk_rx(input string tag, input bq_t e, input int s,
                         input int nfull, input bit eop_exp,
                         input int err_at);
      int lo, hi, n, bad, ne, ebad;
      lo = s + 8;
      hi = s + 8 * e.size() + 1;
      n = 0; bad = 0; ne = 0; ebad = 0;
      for (int i = 0; i < mon_cyc.size(); i++) begin
         if (mon_cyc[i] >= lo && mon_cyc[i] <= hi) begin
            if (n < nfull) begin
               if (mon_data[i] !== e[n]) bad++;
               if (mon_sop[i] !== (n == 0)) bad++;
               if (mon_eop[i] !== (eop_exp && n == e.size() - 1)) bad++;
               if (mon_cyc[i] != s + 8 + 8 * n) bad++;
            end
            n++;
         end
      end
      chk({tag, "/count"}, n, nfull);
      chk({tag, "/bytes"}, bad, 0);
      for (int i = 0; i < err_cyc.size(); i++) begin
         if (err_cyc[i] >= lo && err_cyc[i] <= hi) begin
            ne++;
            if (err_cyc[i] != err_at) ebad++;
         end
      end
      chk({tag, "/err_cnt"}, ne, (err_at >= 0) ? 1 : 0);
      chk({tag, "/err_pos"}, ebad, 0);
   endtask

   task automatic chk_tx(input string tag, input bq_t e, input int n,
                         input bit under);
      int s, bad, nb, ne, ep, tail, endi;
      s = -1; bad = 0; nb = 0; ne = 0; ep = -1; tail = 0;
      for (int i = 0; i < tq_m.size(); i++)
         if (s < 0 && tq_m[i] === 1'b0) s = i;
      chk({tag, "/start_idx"}, s, 2);
      if (s < 0) s = 2;
      endi = s + 1 + 8 * n;
      for (int k = 0; k < n; k++)
         for (int j = 0; j < 8; j++)
            if (tq_m[s + 1 + 8 * k + j] !== e[k][7 - j]) bad++;
      chk({tag, "/bits"}, bad, 0);
      chk({tag, "/end_bit"}, tq_m[endi], 1'b0);
      for (int i = endi + 1; i < tq_m.size(); i++)
         if (tq_m[i] !== 1'b1) tail++;
      chk({tag, "/idle_after"}, tail, 0);
      for (int i = 0; i < tq_b.size(); i++) begin
         if (tq_b[i] === 1'b1) nb++;
         if (tq_e[i] === 1'b1) begin
            ne++;
            ep = i;
         end
      end
      chk({tag, "/busy_len"}, nb, 2 + 8 * n);
      chk({tag, "/busy_at_start"}, tq_b[s], 1'b1);
      chk({tag, "/err_cnt"}, ne, under ? 1 : 0);
      if (under) chk({tag, "/err_pos"}, ep, endi);
   endtask

   initial begin
      bq_t f1, f2, f3;
      int  sa, sb;
      rst      = 1'b1;
      mosi     = 1'b1;
      cs       = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst/rx_valid", rx_valid, 1'b0);
      chk("rst/rx_data", rx_data, 8'h00);
      chk("rst/rx_sop", rx_sop, 1'b0);
      chk("rst/rx_eop", rx_eop, 1'b0);
      chk("rst/rx_err", rx_err, 1'b0);
      chk("rst/miso", miso, 1'b1);
      chk("rst/tx_ready", tx_ready, 1'b1);
      chk("rst/tx_busy", tx_busy, 1'b0);
      chk("rst/tx_err", tx_err, 1'b0);
      rst = 1'b0;
      cs  = 1'b0;
      step(4);

      // Fixed interest frame received.
      clr();
      f1 = mk_fixed(1'b1);
      push_frame(f1, 1'b0);
      step(8 * 9 + 12);
      chk_rx("rx_int", f1, s0, 9, 1'b1, -1);

      // Fixed data frame, then a random frame back-to-back.
      clr();
      f1 = mk_fixed(1'b0);
      f2 = mk_rand(1'($urandom));
      push_frame(f1, 1'b0);
      push_frame(f2, 1'b0);
      step(8 * 82 + 20);
      sa = s0;
      sb = s0 + 8 * 41 + 2;
      chk_rx("rx_dat", f1, sa, 41, 1'b1, -1);
      chk_rx("rx_b2b", f2, sb, f2.size(), 1'b1, -1);

      // Bad end bit.
      clr();
      f1 = mk_rand(1'b1);
      push_frame(f1, 1'b1);
      step(8 * 9 + 12);
      chk_rx("rx_endbit", f1, s0, 9, 1'b1, s0 + 1 + 8 * 9);

      // cs abort in the 3rd prefix byte, then a clean frame.
      clr();
      f1 = mk_rand(1'b0);
      lq.push_back(2'b00);
      for (int k = 0; k < 3; k++) push_byte(f1[k]);
      for (int j = 7; j >= 4; j--) lq.push_back({1'b0, f1[3][j]});
      repeat (5) lq.push_back(2'b11);
      step(60);
      chk_rx("rx_abort", f1, s0, 3, 1'b0, s0 + 29);
      clr();
      f1 = mk_rand(1'($urandom));
      push_frame(f1, 1'b0);
      step(8 * 41 + 12);
      chk_rx("rx_after_abort", f1, s0, f1.size(), 1'b1, -1);

      // Fixed interest TX.
      clr();
      f1 = mk_fixed(1'b1);
      f1[1] = 8'h01; f1[2] = 8'h02; f1[3] = 8'h03; f1[4] = 8'h04;
      f1[5] = 8'h05; f1[6] = 8'h06; f1[7] = 8'h07; f1[8] = 8'h08;
      hq = f1;
      step(90);
      chk_tx("tx_int", f1, 9, 1'b0);

      // Random data TX, full length.
      clr();
      f1 = mk_rand(1'b0);
      hq = f1;
      step(8 * 41 + 16);
      chk_tx("tx_dat", f1, 41, 1'b0);

      // Underrun after 12 bytes of a data frame.
      clr();
      f1 = mk_rand(1'b0);
      for (int k = 0; k < 12; k++) hq.push_back(f1[k]);
      step(8 * 12 + 20);
      chk_tx("tx_under", f1, 12, 1'b1);

      // Concurrent random frames both directions.
      for (int r = 0; r < 3; r++) begin
         clr();
         f1 = mk_rand(1'($urandom));
         f2 = mk_rand(1'($urandom));
         push_frame(f1, 1'b0);
         hq = f2;
         step(8 * 41 + 16);
         chk_rx("rx_conc", f1, s0, f1.size(), 1'b1, -1);
         chk_tx("tx_conc", f2, f2.size(), 1'b0);
      end

      // Reset mid-frame in both directions.
      clr();
      f1 = mk_rand(1'b1);
      f2 = mk_rand(1'b1);
      push_frame(f1, 1'b0);
      hq = f2;
      step(30);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid/miso", miso, 1'b1);
      chk("rst_mid/tx_ready", tx_ready, 1'b1);
      chk("rst_mid/tx_busy", tx_busy, 1'b0);
      chk("rst_mid/rx_valid", rx_valid, 1'b0);
      lq.delete();
      hq.delete();
      tx_valid = 1'b0;
      step(2);
      rst = 1'b0;
      clr();
      step(20);
      chk("rst_mid/no_rx", mon_cyc.size(), 0);
      chk("rst_mid/idle_miso", miso, 1'b1);

      // Fresh interest frames afterwards.
      clr();
      f1 = mk_rand(1'b1);
      f3 = mk_rand(1'b1);
      push_frame(f1, 1'b0);
      hq = f3;
      step(90);
      chk_rx("rx_post_rst", f1, s0, 9, 1'b1, -1);
      chk_tx("tx_post_rst", f3, 9, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
